dualport_fifo_ctrl: RTL and testbench
=====================================

// Module: dualport_fifo_ctrl
// PURPOSE
//   FIFO controller that sequences the 16x8 synchronous dual-port RAM
//   (sync_dualport16_8 family) as a first-in first-out buffer.
//   Valid/ready push and pop handshakes, pointers, occupancy, full/empty flags.
//   Drives the RAM write and read ports and holds the popped word in a
//   one-entry output register.
// PARAMETERS
//   DATA_W  8   data width; equals the RAM word width
//   ADDR_W  4   RAM address width
//   DEPTH   16  RAM entries; must equal 2**ADDR_W
// PORTS
//   clk          in   1         clock; all state updates on posedge
//   rst          in   1         asynchronous, active-low reset (0 = reset)
//   wr_valid     in   1         push request
//   wr_ready     out  1         push accepted when wr_valid && wr_ready
//   wr_data      in   DATA_W    push data
//   rd_valid     out  1         output register holds a word
//   rd_ready     in   1         pop; word consumed when rd_valid && rd_ready
//   rd_data      out  DATA_W    head-of-FIFO word
//   count        out  ADDR_W+1  words held: RAM + in-flight + output register
//   full         out  1         RAM holds DEPTH unread words
//   empty        out  1         count == 0
//   ovf          out  1         sticky: push attempted while full
//   ram_we       out  1         RAM write enable
//   ram_wr_addr  out  ADDR_W    RAM write address
//   ram_din      out  DATA_W    RAM write data
//   ram_re       out  1         RAM read enable
//   ram_rd_addr  out  ADDR_W    RAM read address
//   ram_dout     in   DATA_W    RAM read data; valid the cycle after ram_re
// BEHAVIOUR
//   Reset (rst=0, async):
//   - wptr=rptr=0, ram_cnt=0, state=IDLE
//   - rd_valid=0, rd_data=0, ovf=0; count=0, empty=1, full=0, wr_ready=1
//   - ram_we=0, ram_re=0, RAM addresses 0. RAM contents are not cleared.
//   - Reset mid-transfer discards all words, including an in-flight read.
//   Write side:
//   - full = (ram_cnt == DEPTH); wr_ready = !full
//   - On accept: ram_we=1, ram_wr_addr=wptr, ram_din=wr_data, all in the same
//     cycle (combinational); wptr++ at the edge, wrapping 15 -> 0.
//   - wr_valid while full: no write, pointers unchanged, ovf set until reset.
//   Read FSM (state = IDLE, WAIT, VALID):
//   - IDLE (rd_valid=0): if ram_cnt>0, drive ram_re=1, ram_rd_addr=rptr;
//     rptr++ and ram_cnt-- at the edge, go to WAIT.
//   - WAIT: at the edge, rd_data <= ram_dout; go to VALID.
//   - VALID (rd_valid=1): rd_data is held stable while !rd_ready.
//     On rd_ready with ram_cnt>0: issue the next ram_re this cycle, go to WAIT.
//     On rd_ready with ram_cnt==0: go to IDLE.
//   - Latency: word accepted in cycle t -> rd_valid=1 in cycle t+3 (FIFO empty).
//     Sustained pop rate: 1 word per 2 cycles.
//   Occupancy:
//   - ram_cnt: +1 on accept, -1 on ram_re; both in one cycle -> unchanged.
//   - count = ram_cnt + (state != IDLE); maximum DEPTH+1 = 17.
//   - ram_re is issued only when ram_cnt>0, so a read never targets the address
//     written in the same cycle. No read/write collision can occur.
// TESTING
//   1. Assert rst=0 mid-stream for 1 cycle -> rd_valid=0, count=0, empty=1,
//      wr_ready=1, ovf=0 immediately (asynchronous).
//   2. Push 1..7, rd_ready=0 -> ram_we pulses at addresses 0..6;
//      rd_valid=1 with rd_data=1 three cycles after the first accept; count=7.
//   3. Then rd_ready=1 -> rd_data sequence 1,2,...,7, one word per 2 cycles;
//      afterwards empty=1, rd_valid=0.
//   4. rd_ready=0, push 17 words -> count=17, full=1, wr_ready=0;
//      an 18th push is ignored and ovf=1.
//   5. Stream 40 words (values 0..39) with random rd_ready -> output in order,
//      ram_wr_addr and ram_rd_addr wrap 15 -> 0, no word lost or duplicated.
//   6. count=5, push and RAM read issued in the same cycle -> count stays 5;
//      ram_cnt is unchanged.

Source files
------------

// File: rtl/dualport_fifo_ctrl_if.sv
// Push/pop handshake and status bundle between a FIFO user (master) and the
// FIFO controller (slave).
interface dualport_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              ovf;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count, full, empty, ovf
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count, full, empty, ovf
    );
endinterface

// File: rtl/dualport_fifo_ctrl.sv
// FIFO controller sequencing a synchronous 16x8 dual-port RAM, with a
// one-entry output register holding the head word.
//
// state | meaning
// IDLE  | output register empty, no RAM read in flight
// WAIT  | RAM read issued last cycle, ram_dout lands at this edge
// VALID | output register holds the head word (rd_valid=1)
module dualport_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dualport_fifo_ctrl_if.slave  fifo,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_wr_addr,
    output logic [DATA_W-1:0]    ram_din,
    output logic                 ram_re,
    output logic [ADDR_W-1:0]    ram_rd_addr,
    input  logic [DATA_W-1:0]    ram_dout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] wptr_q,    wptr_d;
    logic [ADDR_W-1:0] rptr_q,    rptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q,     ovf_d;

    logic full;
    logic push;

    assign full = (ram_cnt_q == (ADDR_W+1)'(DEPTH));
    assign push = fifo.wr_valid && !full;

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        ram_re      = 1'b0;
        ram_we      = push;
        ram_wr_addr = wptr_q;
        ram_din     = fifo.wr_data;
        ram_rd_addr = rptr_q;
        ovf_d       = ovf_q | (fifo.wr_valid & full);

        case (state_q)
            IDLE: begin
                if (ram_cnt_q != '0) begin
                    ram_re  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rd_data_d = ram_dout;
                state_d   = VALID;
            end
            VALID: begin
                // Back-to-back pops refill straight from RAM without passing IDLE.
                if (fifo.rd_ready) begin
                    if (ram_cnt_q != '0) begin
                        ram_re  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wptr_d    = wptr_q + ADDR_W'(push);
        rptr_d    = rptr_q + ADDR_W'(ram_re);
        ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(ram_re);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo.wr_ready = !full;
    assign fifo.rd_valid = (state_q == VALID);
    assign fifo.rd_data  = rd_data_q;
    assign fifo.count    = ram_cnt_q + (ADDR_W+1)'(state_q != IDLE);
    assign fifo.full     = full;
    assign fifo.empty    = (fifo.count == '0);
    assign fifo.ovf      = ovf_q;
endmodule

// File: tb/tb_dualport_fifo_ctrl.sv
// Directed bench for dualport_fifo_ctrl with a behavioural synchronous RAM.
module tb_dualport_fifo_ctrl;
    logic       clk;
    logic       rst;
    logic       ram_we;
    logic [3:0] ram_wr_addr;
    logic [7:0] ram_din;
    logic       ram_re;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_dout;
    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    dualport_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(4)) f ();

    dualport_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo        (f.slave),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_din     (ram_din),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .ram_dout    (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int first, input int n);
        int got;
        got = 0;
        f.rd_ready = 1'b1;
        for (int c = 0; c < 200 && got < n; c++) begin
            #1;
            if (f.rd_valid) begin
                chk(tag, int'(f.rd_data), (first + got) & 8'hff);
                got++;
            end
            tick();
        end
        f.rd_ready = 1'b0;
        chk({tag, "_n"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pushed, popped, wa, ra, last, exp;

        rst        = 1'b0;
        f.wr_valid = 1'b0;
        f.wr_data  = '0;
        f.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        tick();

        chk("rst_count",    int'(f.count),    0);
        chk("rst_empty",    int'(f.empty),    1);
        chk("rst_full",     int'(f.full),     0);
        chk("rst_wr_ready", int'(f.wr_ready), 1);
        chk("rst_rd_valid", int'(f.rd_valid), 0);
        chk("rst_rd_data",  int'(f.rd_data),  0);
        chk("rst_ovf",      int'(f.ovf),      0);
        chk("rst_ram_we",   int'(ram_we),     0);
        chk("rst_ram_re",   int'(ram_re),     0);

        // Push 1..7 with no pops; first word reaches the output 3 cycles on.
        for (int i = 1; i <= 7; i++) begin
            f.wr_valid = 1'b1;
            f.wr_data  = 8'(i);
            #1;
            chk("push_we",   int'(ram_we),      1);
            chk("push_addr", int'(ram_wr_addr), i - 1);
            chk("push_din",  int'(ram_din),     i);
            if (i == 2) begin
                chk("first_re",   int'(ram_re),      1);
                chk("first_raddr", int'(ram_rd_addr), 0);
            end
            if (i == 3) chk("lat_early", int'(f.rd_valid), 0);
            if (i == 4) begin
                chk("lat_valid", int'(f.rd_valid), 1);
                chk("lat_data",  int'(f.rd_data),  1);
            end
            tick();
        end
        f.wr_valid = 1'b0;
        tick();
        chk("count7", int'(f.count), 7);
        chk("full7",  int'(f.full),  0);

        // Drain 1..7 at one word per two cycles.
        f.rd_ready = 1'b1;
        exp  = 1;
        last = 0;
        for (int c = 0; c < 40 && exp <= 7; c++) begin
            #1;
            if (f.rd_valid) begin
                chk("pop_data", int'(f.rd_data), exp);
                if (exp > 1) chk("pop_gap", c - last, 2);
                last = c;
                exp++;
            end
            tick();
        end
        f.rd_ready = 1'b0;
        chk("pop_all",     exp, 8);
        chk("pop_empty",   int'(f.empty),    1);
        chk("pop_rdvalid", int'(f.rd_valid), 0);

        // Fill to 17 words, then an overflowing push.
        for (int i = 0; i < 17; i++) begin
            f.wr_valid = 1'b1;
            f.wr_data  = 8'(100 + i);
            #1;
            chk("fill_ready", int'(f.wr_ready), 1);
            tick();
        end
        f.wr_valid = 1'b0;
        tick();
        chk("fill_count", int'(f.count),    17);
        chk("fill_full",  int'(f.full),     1);
        chk("fill_ready_n", int'(f.wr_ready), 0);
        chk("fill_ovf0",  int'(f.ovf),      0);
        f.wr_valid = 1'b1;
        f.wr_data  = 8'd200;
        #1;
        chk("ovf_no_we", int'(ram_we), 0);
        tick();
        f.wr_valid = 1'b0;
        chk("ovf_set",   int'(f.ovf),   1);
        chk("ovf_count", int'(f.count), 17);
        drain("drain_full", 100, 5);
        chk("ovf_sticky", int'(f.ovf), 1);

        // Asynchronous reset mid-stream, checked before any clock edge.
        f.rd_ready = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("arst_rd_valid", int'(f.rd_valid), 0);
        chk("arst_count",    int'(f.count),    0);
        chk("arst_empty",    int'(f.empty),    1);
        chk("arst_wr_ready", int'(f.wr_ready), 1);
        chk("arst_ovf",      int'(f.ovf),      0);
        f.rd_ready = 1'b0;
        @(posedge clk);
        #4 rst = 1'b1;
        tick();
        chk("arst_hold_count", int'(f.count), 0);

        // Stream 0..39 with random back-pressure; pointers wrap.
        pushed = 0; popped = 0; wa = 0; ra = 0;
        for (int c = 0; c < 600 && popped < 40; c++) begin
            f.wr_valid = (pushed < 40);
            f.wr_data  = 8'(pushed);
            f.rd_ready = 1'($urandom_range(0, 1));
            #1;
            if (ram_we) begin
                chk("stream_waddr", int'(ram_wr_addr), wa % 16);
                wa++;
            end
            if (ram_re) begin
                chk("stream_raddr", int'(ram_rd_addr), ra % 16);
                ra++;
            end
            if (f.wr_valid && f.wr_ready) pushed++;
            if (f.rd_valid && f.rd_ready) begin
                chk("stream_data", int'(f.rd_data), popped);
                popped++;
            end
            tick();
        end
        f.wr_valid = 1'b0;
        f.rd_ready = 1'b0;
        chk("stream_popped", popped, 40);
        chk("stream_writes", wa, 40);
        chk("stream_reads",  ra, 40);
        tick();
        chk("stream_empty", int'(f.empty), 1);

        // count=5, push and RAM read in the same cycle.
        for (int i = 0; i < 5; i++) begin
            f.wr_valid = 1'b1;
            f.wr_data  = 8'(50 + i);
            tick();
        end
        f.wr_valid = 1'b0;
        tick();
        chk("sim_count_pre", int'(f.count),    5);
        chk("sim_valid_pre", int'(f.rd_valid), 1);
        chk("sim_data_pre",  int'(f.rd_data),  50);
        f.wr_valid = 1'b1;
        f.wr_data  = 8'd55;
        f.rd_ready = 1'b1;
        #1;
        chk("sim_we", int'(ram_we), 1);
        chk("sim_re", int'(ram_re), 1);
        tick();
        f.wr_valid = 1'b0;
        f.rd_ready = 1'b0;
        #1;
        chk("sim_count_post", int'(f.count),    5);
        chk("sim_valid_post", int'(f.rd_valid), 0);
        drain("drain_sim", 51, 5);
        chk("end_empty", int'(f.empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
